// File: rtl/fifo_wrr_sched.sv
// Weighted round-robin scheduler draining NUM_Q upstream FIFOs onto one
// valid/ready stream through a registered output stage.
module fifo_wrr_sched #(
  parameter int unsigned NUM_Q = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned QW    = 4,
  parameter int unsigned IDX_W = $clog2(NUM_Q)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_Q-1:0]         q_valid,
  input  logic [NUM_Q*WIDTH-1:0]   q_data,
  output logic [NUM_Q-1:0]         q_ready,
  input  logic [NUM_Q*QW-1:0]      weight,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]         out_qid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int unsigned SUM_W = IDX_W + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [QW-1:0]      credit_q, credit_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]   out_qid_q, out_qid_d;

  logic               stage_ready_c;
  logic               xfer_c;
  logic [2*NUM_Q-1:0] vv_c;
  logic [NUM_Q-1:0]   rot_c;
  logic [IDX_W-1:0]   off_c;
  logic [SUM_W-1:0]   sum_c;
  logic [IDX_W-1:0]   pick_c;
  logic [QW-1:0]      pick_w_c;
  logic [WIDTH-1:0]   sel_data_c;
  logic [IDX_W-1:0]   nxt_ptr_c;

  // Rotate valids so bit 0 is the queue at ptr; lowest set bit wins.
  always_comb begin
    vv_c  = {q_valid, q_valid};
    rot_c = NUM_Q'(vv_c >> ptr_q);
    off_c = '0;
    for (int k = int'(NUM_Q) - 1; k >= 0; k--) begin
      if (rot_c[k]) off_c = IDX_W'(k);
    end
    sum_c = SUM_W'(ptr_q) + SUM_W'(off_c);
    if (sum_c >= SUM_W'(NUM_Q)) sum_c = sum_c - SUM_W'(NUM_Q);
    pick_c = IDX_W'(sum_c);
  end

  // Per-queue field selection for the granted data and the candidate weight.
  always_comb begin
    sel_data_c = '0;
    pick_w_c   = '0;
    for (int i = 0; i < int'(NUM_Q); i++) begin
      if (gnt_q == IDX_W'(i))  sel_data_c = q_data[i*WIDTH +: WIDTH];
      if (pick_c == IDX_W'(i)) pick_w_c   = weight[i*QW +: QW];
    end
  end

  assign stage_ready_c = !out_valid_q || out_ready;
  assign xfer_c        = (state_q == SERVE) && q_valid[gnt_q] && stage_ready_c;
  assign nxt_ptr_c     = (gnt_q == IDX_W'(NUM_Q - 1)) ? '0 : gnt_q + IDX_W'(1);

  // Read strobe follows the grant whenever the output stage can take a word.
  always_comb begin
    q_ready = '0;
    for (int i = 0; i < int'(NUM_Q); i++) begin
      q_ready[i] = (state_q == SERVE) && (gnt_q == IDX_W'(i)) && stage_ready_c;
    end
  end

  // Next-state: arbitration in IDLE, burst accounting in SERVE.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    credit_d    = credit_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_qid_d   = out_qid_q;

    case (state_q)
      IDLE: begin
        if (|q_valid) begin
          gnt_d    = pick_c;
          credit_d = (pick_w_c == '0) ? QW'(1) : pick_w_c;
          state_d  = SERVE;
        end
      end
      SERVE: begin
        if (!q_valid[gnt_q]) begin
          // Queue drained: leftover credit is dropped.
          state_d = IDLE;
          ptr_d   = nxt_ptr_c;
        end else if (stage_ready_c) begin
          if (credit_q == QW'(1)) begin
            state_d = IDLE;
            ptr_d   = nxt_ptr_c;
          end else begin
            credit_d = credit_q - QW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (xfer_c) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data_c;
      out_qid_d   = gnt_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      credit_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_qid_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      credit_q    <= credit_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_qid_q   <= out_qid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_qid   = out_qid_q;
  assign busy      = (state_q == SERVE);

endmodule

// File: doc/fifo_wrr_sched.md
# fifo_wrr_sched

Weighted round-robin scheduler that drains NUM_Q upstream FIFOs onto one shared valid/ready output stream. Each FIFO's read side (out_valid/out_data/out_ready) connects to one requester slot. The scheduler grants one queue at a time for a burst of up to `weight` words, then rotates. A registered output stage isolates downstream timing from the queue read ports.

## Interface
- NUM_Q, 4, number of requesting queues (≥2)
- WIDTH, 8, data width
- QW, 4, width of each per-queue weight field
- IDX_W, $clog2(NUM_Q), queue index width

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- q_valid  in  NUM_Q  per-queue data available (FIFO out_valid)
- q_data  in  NUM_Q*WIDTH  per-queue data; queue i at bits [i*WIDTH +: WIDTH]
- q_ready  out  NUM_Q  per-queue read strobe (FIFO out_ready); one-hot or zero
- weight  in  NUM_Q*QW  per-queue burst quota; queue i at [i*QW +: QW]; sampled at grant
- out_valid  out  1  output word valid
- out_data  out  WIDTH  output word
- out_qid  out  IDX_W  source queue of out_data
- out_ready  in  1  downstream accepts
- busy  out  1  high while state is SERVE

## Operation
- FSM states: IDLE, SERVE. Registers: ptr (search start), gnt (granted index), credit (QW bits).
- IDLE: if any q_valid is set, gnt <= first i with q_valid[i] set, searching ptr, ptr+1, … modulo NUM_Q. credit <= weight[gnt], with weight 0 loaded as 1. Next state SERVE. Otherwise remain in IDLE.
- stage_ready = !out_valid || out_ready.
- xfer = (state==SERVE) && q_valid[gnt] && stage_ready.
- q_ready[i] = (state==SERVE) && (i==gnt) && stage_ready. This is combinational, and all bits are 0 in IDLE.
- On xfer: out_data <= q_data[gnt], out_qid <= gnt, out_valid <= 1.
  - If credit==1: state <= IDLE, ptr <= (gnt+1) mod NUM_Q.
  - Otherwise credit <= credit-1.
- No xfer and out_ready: out_valid <= 0.
- SERVE with q_valid[gnt]==0 (queue drained): state <= IDLE, ptr <= (gnt+1) mod NUM_Q. No transfer occurs and the unused credit is discarded.
- SERVE with q_valid[gnt]==1 and stage not ready: hold. credit, gnt and the output register are unchanged.
- weight changes during SERVE do not affect the current burst.
- out_data and out_qid hold their value whenever out_valid && !out_ready.

## Timing
- Reset values: state IDLE, ptr 0, gnt 0, credit 0, out_valid 0, out_data 0, out_qid 0, q_ready 0, busy 0.
- Reset asserted mid-burst: all state clears immediately. The word in the output register is lost. Upstream FIFOs see q_ready=0.
- Latency: q_valid high in IDLE at edge N → grant at edge N → xfer on cycle N+1 → out_valid high after edge N+1.
- Throughput: one word per cycle within a burst while out_ready=1.
- Grant boundary: exactly one idle cycle between bursts, because IDLE performs arbitration. Peak rate is therefore W/(W+1) for burst length W.
- Wrap-around: the search after a grant on queue NUM_Q-1 starts at queue 0.
- A queue that is valid but not granted receives no q_ready.
- Fairness: every queue with continuous q_valid is granted within NUM_Q grants.

## Test plan
- Reset: hold rst_n low with random inputs → out_valid=0, q_ready=0, busy=0, out_qid=0. Release rst_n → first grant goes to the lowest-indexed valid queue.
- Single queue 0, weight 3, 7 words, out_ready=1:
  - out_data follows FIFO order, out_qid=0 throughout.
  - Pattern is 3 words, 1 bubble, 3 words, 1 bubble, 1 word.
  - Grant then ends on drain and busy=0.
- Queues 0 and 1 always valid, weights 2 and 1 → out_qid sequence 0,0,1,0,0,1, …
- Weight 0 on queue 2 while all queues are valid → queue 2 gets exactly 1 word per rotation. Queue 3 is served after queue 2; queue 0 is served after queue 3 (wrap).
- Backpressure: hold out_ready=0 for 5 cycles mid-burst → out_data, out_qid and credit stay stable, q_ready=0. Release → the burst resumes with no loss or duplication.
- Queue 1 (weight 4) drops q_valid after 2 words → SERVE exits to IDLE and ptr=2. Reset pulsed mid-burst → out_valid falls asynchronously. After release, arbitration restarts from queue 0.
